// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/RAM-state definitions plus the memory-arbiter state
// encoding and the word returned on an aborted access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam word_t ARB_ERR_WORD = 32'hBAD0_BAD0;

endpackage

// File: rtl/arb_timer.sv
// Grant watchdog: cleared while the arbiter is idle, counts granted cycles,
// and holds at TIMEOUT-1 so an expired access cannot wrap back to zero.
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM between the instruction and data ports: data
// wins by default, a bounded data streak lets a pending fetch through.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t  state, nextState;
  logic [SW-1:0] dstreak;
  logic        dReq, streakFull, timerExpired;
  logic        selD, selI, dHit, iHit, dErr, iErr;

  assign dReq       = dREN | dWEN;
  assign streakFull = (dstreak == SW'(MAX_DSTREAK));

  arb_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .count   (state != IDLE),
    .expired (timerExpired)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    selD      = 1'b0;
    selI      = 1'b0;
    dHit      = 1'b0;
    iHit      = 1'b0;
    dErr      = 1'b0;
    iErr      = 1'b0;
    case (state)
      IDLE: begin
        // Selection is gated by nRST so enables stay low while reset is held.
        if (nRST) begin
          if (dReq && !(iREN && streakFull)) begin
            selD      = 1'b1;
            nextState = DGRANT;
          end else if (iREN) begin
            selI      = 1'b1;
            nextState = IGRANT;
          end
        end
      end
      DGRANT: begin
        selD = 1'b1;
        if (!dReq) begin
          nextState = IDLE;
        end else if (ramstate == ACCESS) begin
          dHit      = 1'b1;
          nextState = IDLE;
        end else if (ramstate == ERROR || timerExpired) begin
          dErr      = 1'b1;
          nextState = IDLE;
        end
      end
      IGRANT: begin
        selI = 1'b1;
        if (!iREN) begin
          nextState = IDLE;
        end else if (ramstate == ACCESS) begin
          iHit      = 1'b1;
          nextState = IDLE;
        end else if (ramstate == ERROR || timerExpired) begin
          iErr      = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Enables follow the live request, so a withdrawn request drops them at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (selD) begin
      ramREN   = dREN & ~dWEN;
      ramWEN   = dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
    end else if (selI) begin
      ramREN   = iREN;
      ramaddr  = iaddr;
    end
  end

  assign dwait = ~(dHit | dErr);
  assign iwait = ~(iHit | iErr);
  assign dload = dErr ? ARB_ERR_WORD : ((dHit && !dWEN) ? ramload : '0);
  assign iload = iErr ? ARB_ERR_WORD : (iHit ? ramload : '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      arb_err <= 1'b0;
    end else begin
      state <= nextState;
      if (dErr || iErr) begin
        arb_err <= 1'b1;
      end
      if (!iREN || iHit) begin
        dstreak <= '0;
      end else if (dHit && !streakFull) begin
        dstreak <= dstreak + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int MAXS    = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  word_t     iload, dload, ramaddr, ramstore;
  logic      iwait, dwait, ramREN, ramWEN, arb_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DSTREAK(MAXS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
  endtask

  // Leaves the bench at a falling edge with reset released and the DUT idle.
  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #1;
    check(iwait === 1'b1 && dwait === 1'b1,
          $sformatf("reset_waits got i=%b d=%b expected 1 1", iwait, dwait));
    check({ramREN, ramWEN, arb_err} === 3'b000,
          $sformatf("reset_flags got ren=%b wen=%b err=%b expected 0 0 0", ramREN, ramWEN, arb_err));
    check(ramaddr === 0 && ramstore === 0 && iload === 0 && dload === 0,
          $sformatf("reset_buses got addr=%h store=%h il=%h dl=%h expected 0", ramaddr, ramstore, iload, dload));
    @(negedge CLK);
    nRST = 1'b1;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234_5678; ramstate = BUSY;
    #1;
    check(ramWEN === 1'b1 && ramaddr === 32'h80,
          $sformatf("reset_select got wen=%b addr=%h expected 1 00000080", ramWEN, ramaddr));
    @(negedge CLK);
    #1;
    check(ramWEN === 1'b1 && dwait === 1'b1,
          $sformatf("reset_grant got wen=%b dwait=%b expected 1 1", ramWEN, dwait));
    #1 nRST = 1'b0;
    #1;
    check(ramWEN === 1'b0 && ramREN === 1'b0,
          $sformatf("reset_mid_enables got wen=%b ren=%b expected 0 0", ramWEN, ramREN));
    check(iwait === 1'b1 && dwait === 1'b1 && arb_err === 1'b0,
          $sformatf("reset_mid_status got i=%b d=%b err=%b expected 1 1 0", iwait, dwait, arb_err));
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;
  endtask

  task automatic test_instr_only();
    word_t expLoad;
    logic  expWait;
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin ramstate = ACCESS; ramload = 32'h8C22_0004; end
      expWait = (c == 3) ? 1'b0 : 1'b1;
      expLoad = (c == 3) ? 32'h8C22_0004 : 32'h0;
      #1;
      check(ramREN === 1'b1 && ramaddr === 32'h40,
            $sformatf("instr_drive c%0d got ren=%b addr=%h expected 1 00000040", c, ramREN, ramaddr));
      check(iwait === expWait && iload === expLoad,
            $sformatf("instr_resp c%0d got wait=%b load=%h expected %b %h", c, iwait, iload, expWait, expLoad));
      check(dwait === 1'b1,
            $sformatf("instr_dwait c%0d got %b expected 1", c, dwait));
      @(negedge CLK);
    end
    iREN = 1'b0; ramstate = FREE;
    #1;
    check(iwait === 1'b1 && ramREN === 1'b0,
          $sformatf("instr_after got wait=%b ren=%b expected 1 0", iwait, ramREN));
    @(negedge CLK);
  endtask

  task automatic test_priority();
    do_reset();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
    #1;
    check(ramaddr === 32'h100 && ramREN === 1'b1 && iwait === 1'b1,
          $sformatf("prio_select got addr=%h ren=%b iwait=%b expected 00000100 1 1", ramaddr, ramREN, iwait));
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h1111_2222;
    #1;
    check(dwait === 1'b0 && dload === 32'h1111_2222,
          $sformatf("prio_dhit got dwait=%b dload=%h expected 0 11112222", dwait, dload));
    check(iwait === 1'b1 && iload === 32'h0,
          $sformatf("prio_ihold got iwait=%b iload=%h expected 1 00000000", iwait, iload));
    @(negedge CLK);
    dREN = 1'b0; ramstate = BUSY;
    #1;
    check(ramaddr === 32'h44 && iwait === 1'b1,
          $sformatf("prio_isel got addr=%h iwait=%b expected 00000044 1", ramaddr, iwait));
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h3333_4444;
    #1;
    check(iwait === 1'b0 && iload === 32'h3333_4444,
          $sformatf("prio_ihit got iwait=%b iload=%h expected 0 33334444", iwait, iload));
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_starvation();
    int seq[$];
    int expSeq[6] = '{1, 1, 1, 1, 2, 1};
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h50; daddr = 32'h150; ramstate = ACCESS;
    for (int c = 0; c < 30 && seq.size() < 6; c++) begin
      ramload = $urandom;
      #1;
      if (dwait === 1'b0) seq.push_back(1);
      if (iwait === 1'b0) seq.push_back(2);
      @(negedge CLK);
    end
    check(seq.size() == 6,
          $sformatf("starve_count got %0d hits expected 6", seq.size()));
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      check(seq[i] == expSeq[i],
            $sformatf("starve_order hit%0d got port %0d expected %0d (1=data 2=instr)", i, seq[i], expSeq[i]));
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramload = 32'hFFFF_0000; ramstate = BUSY;
    #1;
    check(ramWEN === 1'b1 && ramREN === 1'b0 && ramstore === 32'hDEAD_BEEF && ramaddr === 32'h200,
          $sformatf("write_drive got wen=%b ren=%b store=%h addr=%h expected 1 0 deadbeef 00000200",
                    ramWEN, ramREN, ramstore, ramaddr));
    @(negedge CLK);
    ramstate = ACCESS;
    #1;
    check(dwait === 1'b0 && dload === 32'h0,
          $sformatf("write_done got dwait=%b dload=%h expected 0 00000000", dwait, dload));
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_timeout();
    int hitCycle = -1;
    do_reset();
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; ramload = 32'h5555_5555;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (dwait === 1'b0) begin
        hitCycle = c;
        check(dload === ARB_ERR_WORD,
              $sformatf("timeout_load got %h expected bad0bad0", dload));
      end
      @(negedge CLK);
      if (hitCycle != -1) break;
    end
    check(hitCycle == TIMEOUT + 1,
          $sformatf("timeout_cycle got %0d expected %0d", hitCycle, TIMEOUT + 1));
    #1;
    check(arb_err === 1'b1,
          $sformatf("timeout_err got %b expected 1", arb_err));
    dREN = 1'b0; ramstate = ACCESS;
    repeat (3) @(negedge CLK);
    #1;
    check(arb_err === 1'b1,
          $sformatf("timeout_sticky got %b expected 1", arb_err));
    do_reset();
    #1;
    check(arb_err === 1'b0,
          $sformatf("timeout_clear got %b expected 0", arb_err));
    @(negedge CLK);
  endtask

  // Model: one transaction in flight (owner 0=none 1=data 2=instr) with its
  // age in granted cycles; a new owner is picked in the cycle it is free.
  task automatic test_random();
    int owner = 0, age = 0, streak = 0;
    bit err = 1'b0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int    cur, nxt, r;
      bit    fresh, dq, req, dDone, iDone, errNow;
      logic  eRen, eWen, eDw, eIw;
      word_t eAddr, eStore, eDl, eIl;

      if (iREN) iREN = ($urandom_range(9) != 0);
      else      iREN = $urandom_range(1);
      if (dREN || dWEN) begin
        if ($urandom_range(9) == 0) begin dREN = 1'b0; dWEN = 1'b0; end
      end else begin
        r = $urandom_range(3);
        dREN = (r == 0 || r == 2);
        dWEN = (r == 1 || r == 2);
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(99);
      ramstate = (r < 40) ? BUSY : (r < 85) ? ACCESS : (r < 98) ? FREE : ERROR;

      dq = dREN || dWEN;
      cur = owner; fresh = 1'b0;
      if (cur == 0) begin
        if (dq && !(iREN && streak == MAXS)) cur = 1;
        else if (iREN) cur = 2;
        fresh = (cur != 0);
      end
      eRen = 1'b0; eWen = 1'b0; eAddr = '0; eStore = '0;
      eDw = 1'b1; eIw = 1'b1; eDl = '0; eIl = '0;
      nxt = cur; dDone = 1'b0; iDone = 1'b0; errNow = 1'b0;
      if (cur == 1) begin eRen = dREN && !dWEN; eWen = dWEN; eAddr = daddr; eStore = dstore; end
      if (cur == 2) begin eRen = iREN; eAddr = iaddr; end
      if (fresh) begin
        age = 0;
      end else if (cur != 0) begin
        req = (cur == 1) ? dq : iREN;
        if (!req) begin
          nxt = 0;
        end else if (ramstate == ACCESS) begin
          nxt = 0;
          if (cur == 1) begin eDw = 1'b0; eDl = dWEN ? 32'h0 : ramload; dDone = 1'b1; end
          else          begin eIw = 1'b0; eIl = ramload; iDone = 1'b1; end
        end else if (ramstate == ERROR || age == TIMEOUT - 1) begin
          nxt = 0; errNow = 1'b1;
          if (cur == 1) begin eDw = 1'b0; eDl = ARB_ERR_WORD; end
          else          begin eIw = 1'b0; eIl = ARB_ERR_WORD; end
        end else begin
          age++;
        end
      end

      #1;
      check(ramREN === eRen && ramWEN === eWen && ramaddr === eAddr && ramstore === eStore,
            $sformatf("rand_ram n%0d got ren=%b wen=%b addr=%h store=%h expected %b %b %h %h",
                      n, ramREN, ramWEN, ramaddr, ramstore, eRen, eWen, eAddr, eStore));
      check(dwait === eDw && iwait === eIw,
            $sformatf("rand_wait n%0d got d=%b i=%b expected %b %b", n, dwait, iwait, eDw, eIw));
      check(dload === eDl && iload === eIl,
            $sformatf("rand_load n%0d got d=%h i=%h expected %h %h", n, dload, iload, eDl, eIl));
      check(arb_err === err,
            $sformatf("rand_err n%0d got %b expected %b", n, arb_err, err));

      owner = nxt;
      err = err | errNow;
      if (!iREN || iDone)              streak = 0;
      else if (dDone && streak < MAXS) streak++;
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_instr_only();
    test_priority();
    test_starvation();
    test_write();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
